// File: rtl/gaussian_window_ctrl.sv
// gaussian_window_ctrl
//   Sequencer for the 3x3 Gaussian filter datapath (gaussian_func). Takes a raster
//   pixel stream, keeps two line buffers, builds the 3x3 window, drives the filter
//   enable and tags its two-enable pipeline so that only interior-pixel results are
//   reported as a valid/last-tagged output stream.
// Ports
//   clk, rst          clock; synchronous active-low reset
//   start             begins a frame (only honoured in IDLE)
//   s_valid/s_ready   input handshake, s_data pixel in raster order
//   filt_en           enable to gaussian_func
//   win_p1..win_p9    window to gaussian_func in1..in9 (p1 top-left, p9 bottom-right)
//   filt_out          result from gaussian_func
//   m_valid/m_data    output stream (m_data is filt_out passed straight through)
//   m_last            marks the final output of the frame
//   busy              controller is not IDLE
//   frame_done        one-cycle pulse in DONE
module gaussian_window_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_W      = 640,
    parameter int unsigned IMG_H      = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  filt_en,
    output logic [DATA_WIDTH-1:0] win_p1,
    output logic [DATA_WIDTH-1:0] win_p2,
    output logic [DATA_WIDTH-1:0] win_p3,
    output logic [DATA_WIDTH-1:0] win_p4,
    output logic [DATA_WIDTH-1:0] win_p5,
    output logic [DATA_WIDTH-1:0] win_p6,
    output logic [DATA_WIDTH-1:0] win_p7,
    output logic [DATA_WIDTH-1:0] win_p8,
    output logic [DATA_WIDTH-1:0] win_p9,
    input  logic [DATA_WIDTH-1:0] filt_out,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned COL_W     = $clog2(IMG_W);
    localparam int unsigned ROW_W     = $clog2(IMG_H);
    localparam int unsigned TOTAL_OUT = (IMG_W - 2) * (IMG_H - 2);
    localparam int unsigned CNT_W     = $clog2(TOTAL_OUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_n;
    logic                flush_cnt, flush_cnt_n;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic [CNT_W-1:0]    out_cnt;
    logic                win_ok;
    logic                tag0;

    logic [DATA_WIDTH-1:0] lb1 [IMG_W];
    logic [DATA_WIDTH-1:0] lb2 [IMG_W];
    logic [DATA_WIDTH-1:0] lb1_rd_c;
    logic [DATA_WIDTH-1:0] lb2_rd_c;

    logic accept_c;
    logic last_px_c;
    logic emit_c;

    assign accept_c  = s_valid && s_ready;
    assign last_px_c = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
    // A result is reported when the filter advances and the window enabled one step earlier was interior.
    assign emit_c    = filt_en && tag0;
    assign lb1_rd_c  = lb1[col];
    assign lb2_rd_c  = lb2[col];
    assign m_data    = filt_out;

    // Next-state logic
    always_comb begin
        state_n     = state;
        flush_cnt_n = flush_cnt;
        case (state)
            IDLE: begin
                if (start) state_n = RUN;
            end
            RUN: begin
                if (accept_c && last_px_c) begin
                    state_n     = FLUSH;
                    flush_cnt_n = 1'b0;
                end
            end
            FLUSH: begin
                if (flush_cnt) state_n = DONE;
                else           flush_cnt_n = 1'b1;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Line buffers: contents never reset; rows 0 and 1 of every frame mask stale data.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lb2[col] <= lb1_rd_c;
            lb1[col] <= s_data;
        end
    end

    // State, counters, window, enable and tag pipeline
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            flush_cnt  <= 1'b0;
            col        <= '0;
            row        <= '0;
            out_cnt    <= '0;
            win_ok     <= 1'b0;
            tag0       <= 1'b0;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            filt_en    <= 1'b0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            win_p1     <= '0;
            win_p2     <= '0;
            win_p3     <= '0;
            win_p4     <= '0;
            win_p5     <= '0;
            win_p6     <= '0;
            win_p7     <= '0;
            win_p8     <= '0;
            win_p9     <= '0;
        end else begin
            state      <= state_n;
            flush_cnt  <= flush_cnt_n;
            s_ready    <= (state_n == RUN);
            busy       <= (state_n != IDLE);
            frame_done <= (state_n == DONE);

            if (state == IDLE && start) begin
                col     <= '0;
                row     <= '0;
                out_cnt <= '0;
            end

            if (accept_c) begin
                if (col == COL_W'(IMG_W - 1)) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
                win_p1 <= win_p2;
                win_p2 <= win_p3;
                win_p3 <= lb2_rd_c;
                win_p4 <= win_p5;
                win_p5 <= win_p6;
                win_p6 <= lb1_rd_c;
                win_p7 <= win_p8;
                win_p8 <= win_p9;
                win_p9 <= s_data;
            end

            // Flush enables carry win_ok=0 and only push the last real windows out.
            filt_en <= accept_c || (state == FLUSH);
            win_ok  <= accept_c && (row >= ROW_W'(2)) && (col >= COL_W'(2));

            if (filt_en) tag0 <= win_ok;

            m_valid <= emit_c;
            m_last  <= emit_c && (out_cnt == CNT_W'(TOTAL_OUT - 1));
            if (emit_c) out_cnt <= out_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Bench for gaussian_window_ctrl with a behavioural two-enable gaussian_func model.
module tb_gaussian_window_ctrl;

    localparam int DW   = 8;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NOUT = (W - 2) * (H - 2);
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          filt_en;
    logic [DW-1:0] win_p1, win_p2, win_p3, win_p4, win_p5, win_p6, win_p7, win_p8, win_p9;
    logic [DW-1:0] filt_out;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          frame_done;

    gaussian_window_ctrl #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .filt_en(filt_en),
        .win_p1(win_p1), .win_p2(win_p2), .win_p3(win_p3),
        .win_p4(win_p4), .win_p5(win_p5), .win_p6(win_p6),
        .win_p7(win_p7), .win_p8(win_p8), .win_p9(win_p9),
        .filt_out(filt_out),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // gaussian_func model: weighted sum /16 (truncating), two register stages advanced by enable.
    logic [11:0]   sum_c;
    logic [DW-1:0] s1 = '0;
    logic [DW-1:0] fout = '0;
    assign sum_c = {4'b0, win_p1} + {3'b0, win_p2, 1'b0} + {4'b0, win_p3}
                 + {3'b0, win_p4, 1'b0} + {2'b0, win_p5, 2'b0} + {3'b0, win_p6, 1'b0}
                 + {4'b0, win_p7} + {3'b0, win_p8, 1'b0} + {4'b0, win_p9};
    always @(posedge clk) begin
        if (filt_en) begin
            s1   <= sum_c[11:4];
            fout <= s1;
        end
    end
    assign filt_out = fout;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t   q[$];
    exp_t   e;
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    int     n_out = 0, n_last = 0, n_done = 0, n_fen = 0;
    int     first_mv_cyc = -1;
    int     acc18_cyc = 0, last_acc_cyc = 0, done_cyc = 0;
    bit     ignore_out = 1'b0;
    logic [DW-1:0] img [H][W];

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    always @(negedge clk) begin
        if (rst) begin
            if (m_valid) begin
                n_out++;
                if (first_mv_cyc < 0) first_mv_cyc = cyc;
                if (!ignore_out) begin
                    if (q.size() == 0) begin
                        chk("unexpected_m_valid", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("m_data", int'(m_data), int'(e.d));
                        chk("m_last", int'(m_last), int'(e.l));
                    end
                end
            end
            if (m_last)     n_last++;
            if (frame_done) n_done++;
            if (filt_en)    n_fen++;
        end
    end

    task automatic set_const(input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = DW'(v);
    endtask

    task automatic set_impulse();
        set_const(0);
        img[3][3] = 8'd255;
    endtask

    task automatic set_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = DW'(c * 10);
    endtask

    task automatic push_const(input int v);
        for (int i = 0; i < NOUT; i++) q.push_back('{d: DW'(v), l: (i == NOUT - 1)});
    endtask

    // Hand values: centre 255*4/16=63, edge 255*2/16=31, corner 255/16=15.
    task automatic push_impulse();
        int i = 0;
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                int dr = (r > 3) ? r - 3 : 3 - r;
                int dc = (c > 3) ? c - 3 : 3 - c;
                int v;
                if (dr == 0 && dc == 0)          v = 63;
                else if (dr + dc == 1)           v = 31;
                else if (dr == 1 && dc == 1)     v = 15;
                else                             v = 0;
                q.push_back('{d: DW'(v), l: (i == NOUT - 1)});
                i++;
            end
        end
    endtask

    // Ramp col*10: weights 4/8/4 across columns give exactly 10*centre_col.
    task automatic push_ramp();
        int i = 0;
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                q.push_back('{d: DW'(c * 10), l: (i == NOUT - 1)});
                i++;
            end
        end
    endtask

    task automatic send_frame(input bit gaps, input int stop_after, input int start_mid_at);
        int idx = 0;
        int guard = 0;
        bit v;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (idx < stop_after && guard < 5000) begin
            v       = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            s_valid = v;
            s_data  = img[idx / W][idx % W];
            start   = (start_mid_at >= 0) && (idx == start_mid_at);
            if (v && s_ready) begin
                if (idx == 18) acc18_cyc = cyc;
                last_acc_cyc = cyc;
                idx++;
            end
            @(negedge clk);
            guard++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        if (guard >= 5000) chk("send_timeout", idx, stop_after);
    endtask

    task automatic wait_done();
        int g = 0;
        while (!frame_done && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (frame_done) done_cyc = cyc;
        else chk("done_timeout", 0, 1);
    endtask

    int o0, l0, d0, f0;
    task automatic snap();
        o0 = n_out; l0 = n_last; d0 = n_done; f0 = n_fen;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_filt_en", int'(filt_en), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_win_p5", int'(win_p5), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: constant 100, continuous
        set_const(100); push_const(100); snap(); first_mv_cyc = -1;
        send_frame(1'b0, NPIX, -1);
        wait_done();
        chk("t1_done_latency", done_cyc - last_acc_cyc, 3);
        chk("t1_first_out_latency", first_mv_cyc - acc18_cyc, 3);
        repeat (4) @(negedge clk);
        chk("t1_outputs", n_out - o0, NOUT);
        chk("t1_last_count", n_last - l0, 1);
        chk("t1_done_count", n_done - d0, 1);
        chk("t1_filt_en_count", n_fen - f0, NPIX + 2);

        // 2: impulse, continuous
        set_impulse(); push_impulse(); snap();
        send_frame(1'b0, NPIX, -1);
        wait_done();
        repeat (4) @(negedge clk);
        chk("t2_outputs", n_out - o0, NOUT);

        // 3: impulse with random valid gaps
        push_impulse(); snap();
        send_frame(1'b1, NPIX, -1);
        wait_done();
        repeat (4) @(negedge clk);
        chk("t3_outputs", n_out - o0, NOUT);
        chk("t3_filt_en_count", n_fen - f0, NPIX + 2);
        chk("t3_scoreboard_empty", q.size(), 0);

        // 4: reset after 20 pixels, then a clean constant-50 frame
        set_const(50); ignore_out = 1'b1;
        send_frame(1'b0, 20, -1);
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); ignore_out = 1'b0; snap();
        repeat (10) @(negedge clk);
        chk("t4_quiet_after_reset", n_out - o0, 0);
        chk("t4_busy_after_reset", int'(busy), 0);
        push_const(50); snap();
        send_frame(1'b0, NPIX, -1);
        wait_done();
        repeat (4) @(negedge clk);
        chk("t4_outputs", n_out - o0, NOUT);

        // 5: start pulsed during RUN and during FLUSH
        set_const(77); push_const(77); snap();
        send_frame(1'b0, NPIX, 30);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);
        chk("t5_outputs", n_out - o0, NOUT);
        chk("t5_done_count", n_done - d0, 1);
        chk("t5_filt_en_count", n_fen - f0, NPIX + 2);
        chk("t5_busy_idle", int'(busy), 0);

        // 6: back-to-back ramp frames
        set_ramp(); push_ramp(); push_ramp(); snap();
        send_frame(1'b0, NPIX, -1);
        wait_done();
        send_frame(1'b0, NPIX, -1);
        wait_done();
        repeat (4) @(negedge clk);
        chk("t6_outputs", n_out - o0, 2 * NOUT);
        chk("t6_last_count", n_last - l0, 2);
        chk("t6_done_count", n_done - d0, 2);

        chk("final_scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
